gnn_out_serializer: RTL

GNN_OUT_SERIALIZER -- requirements
Module: gnn_out_serializer

---
 rtl/gnn_out_serializer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/gnn_out_serializer.sv
// gnn_out_serializer: captures eight signed 21-bit layer-2 results when
// all ready flags agree, then streams them as valid/ready beats.
//
// Ports:
//   clk, rst                   clock, async active-high reset
//   outK_nodeN                 signed results (beat index N*2+K)
//   out1K_ready_nodeN          per-result ready flags
//   m_ready                    downstream accepts the current beat
//   sticky_clr                 clears overflow / flag_err
//   m_valid, m_data, m_idx     beat valid, signed data, index
//   m_last                     high on the index-7 beat
//   busy                       high while draining a frame
//   overflow                   sticky: a frame arrived mid-drain, dropped
//   flag_err                   sticky: ready flags disagreed
//   frame_cnt                  completed frames, modulo 256
module gnn_out_serializer (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [20:0] out0_node0,
    input  logic signed [20:0] out1_node0,
    input  logic signed [20:0] out0_node1,
    input  logic signed [20:0] out1_node1,
    input  logic signed [20:0] out0_node2,
    input  logic signed [20:0] out1_node2,
    input  logic signed [20:0] out0_node3,
    input  logic signed [20:0] out1_node3,
    input  logic               out10_ready_node0,
    input  logic               out11_ready_node0,
    input  logic               out10_ready_node1,
    input  logic               out11_ready_node1,
    input  logic               out10_ready_node2,
    input  logic               out11_ready_node2,
    input  logic               out10_ready_node3,
    input  logic               out11_ready_node3,
    input  logic               m_ready,
    input  logic               sticky_clr,
    output logic               m_valid,
    output logic signed [20:0] m_data,
    output logic [2:0]         m_idx,
    output logic               m_last,
    output logic               busy,
    output logic               overflow,
    output logic               flag_err,
    output logic [7:0]         frame_cnt
);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic signed [20:0] buf_q [8];
    logic signed [20:0] buf_d [8];
    logic signed [20:0] din   [8];
    logic               ovf_q, ovf_d;
    logic               ferr_q, ferr_d;
    logic [7:0]         fc_q, fc_d;
    logic [7:0]         rdy;
    logic               capture, partial;
    logic               xfer, last_xfer;

    // Bit position equals beat index node*2 + out.
    assign rdy = {out11_ready_node3, out10_ready_node3,
                  out11_ready_node2, out10_ready_node2,
                  out11_ready_node1, out10_ready_node1,
                  out11_ready_node0, out10_ready_node0};

    always_comb begin
        din[0] = out0_node0;
        din[1] = out1_node0;
        din[2] = out0_node1;
        din[3] = out1_node1;
        din[4] = out0_node2;
        din[5] = out1_node2;
        din[6] = out0_node3;
        din[7] = out1_node3;
    end

    assign capture   = &rdy;
    assign partial   = (|rdy) & ~capture;
    assign xfer      = (state_q == DRAIN) && m_ready;
    assign last_xfer = xfer && (idx_q == 3'd7);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        fc_d    = fc_q;
        // Clear first so that a same-cycle set event overrides it.
        ovf_d   = sticky_clr ? 1'b0 : ovf_q;
        ferr_d  = sticky_clr ? 1'b0 : ferr_q;
        if (partial) ferr_d = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    buf_d   = din;
                    idx_d   = 3'd0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_xfer) begin
                    fc_d = fc_q + 8'd1;
                    if (capture) begin
                        // Back-to-back frame: reload with no bubble.
                        buf_d = din;
                        idx_d = 3'd0;
                    end else begin
                        // idx stays at 7 so m_data/m_idx hold in IDLE.
                        state_d = IDLE;
                    end
                end else begin
                    if (xfer) idx_d = idx_q + 3'd1;
                    if (capture) ovf_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
            fc_q    <= 8'd0;
            for (int i = 0; i < 8; i++) buf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
            ferr_q  <= ferr_d;
            fc_q    <= fc_d;
            buf_q   <= buf_d;
        end
    end

    assign m_valid   = (state_q == DRAIN);
    assign m_data    = buf_q[idx_q];
    assign m_idx     = idx_q;
    assign m_last    = m_valid && (idx_q == 3'd7);
    assign busy      = m_valid;
    assign overflow  = ovf_q;
    assign flag_err  = ferr_q;
    assign frame_cnt = fc_q;

endmodule
